// File: rtl/alu_req_arbiter_if.sv
// Bundle of request, shared-ALU and response signals for alu_req_arbiter.
// slave  : the arbiter side (takes requests, drives the ALU, returns responses).
// master : the environment side (requesters, ALU units, response consumer).
interface alu_req_arbiter_if #(
    parameter int In_out = 16
);
    logic              REQ0_VALID;
    logic              REQ1_VALID;
    logic              REQ0_READY;
    logic              REQ1_READY;
    logic [In_out-1:0] REQ0_A;
    logic [In_out-1:0] REQ0_B;
    logic [In_out-1:0] REQ1_A;
    logic [In_out-1:0] REQ1_B;
    logic [3:0]        REQ0_FUN;
    logic [3:0]        REQ1_FUN;

    logic [In_out-1:0] ALU_A;
    logic [In_out-1:0] ALU_B;
    logic [3:0]        ALU_FUN;
    logic              ARITH_EN;
    logic              LOGIC_EN;
    logic              CMP_EN;
    logic              SHIFT_EN;
    logic [In_out-1:0] ALU_OUT;
    logic              ALU_FLAG;

    logic              RSP_VALID;
    logic              RSP_READY;
    logic              RSP_ID;
    logic [In_out-1:0] RSP_DATA;
    logic              RSP_FLAG;

    modport slave (
        input  REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B, REQ0_FUN, REQ1_FUN,
        output REQ0_READY, REQ1_READY,
        output ALU_A, ALU_B, ALU_FUN, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN,
        input  ALU_OUT, ALU_FLAG,
        output RSP_VALID, RSP_ID, RSP_DATA, RSP_FLAG,
        input  RSP_READY
    );

    modport master (
        output REQ0_VALID, REQ1_VALID, REQ0_A, REQ0_B, REQ1_A, REQ1_B, REQ0_FUN, REQ1_FUN,
        input  REQ0_READY, REQ1_READY,
        input  ALU_A, ALU_B, ALU_FUN, ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN,
        output ALU_OUT, ALU_FLAG,
        input  RSP_VALID, RSP_ID, RSP_DATA, RSP_FLAG,
        output RSP_READY
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter in front of a shared, registered ALU.
// One operation in flight: IDLE (grant) -> EXEC (one unit enabled) ->
// CAPT (unit output settles, captured at end) -> RESP (hold until taken).
// Build option: define ALU_ARB_RR_EN for round-robin tie-break; without it
// requester 0 always wins a tie and no pointer register exists.
module alu_req_arbiter #(
    parameter int In_out = 16
) (
    input logic              CLK,
    input logic              RST,
    alu_req_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        CAPT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              grant_vld;
    logic              grant_id;
    logic              accept;

    logic [In_out-1:0] a_p0;
    logic [In_out-1:0] b_p0;
    logic [3:0]        fun_p0;
    logic              id_p0;

    logic [In_out-1:0] data_p1;
    logic              flag_p1;
    logic              id_p1;

    assign grant_vld = bus.REQ0_VALID | bus.REQ1_VALID;
    assign accept    = (state == IDLE) && grant_vld;

`ifdef ALU_ARB_RR_EN
    logic rr_ptr;

    // Tie-break pointer: names the requester that wins the next tie, moves only on accept.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rr_ptr <= 1'b0;
        end else if (accept) begin
            rr_ptr <= ~grant_id;
        end
    end

    // Tie goes to the pointer; otherwise the single valid requester wins.
    always_comb begin
        if (bus.REQ0_VALID && bus.REQ1_VALID) begin
            grant_id = rr_ptr;
        end else begin
            grant_id = bus.REQ1_VALID;
        end
    end
`else
    // Fixed priority: requester 1 only when requester 0 is idle.
    assign grant_id = bus.REQ1_VALID & ~bus.REQ0_VALID;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, grant strobes and the single-cycle unit enable.
    always_comb begin
        state_nxt      = state;
        bus.REQ0_READY = 1'b0;
        bus.REQ1_READY = 1'b0;
        bus.ARITH_EN   = 1'b0;
        bus.LOGIC_EN   = 1'b0;
        bus.CMP_EN     = 1'b0;
        bus.SHIFT_EN   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_vld) begin
                    bus.REQ0_READY = ~grant_id;
                    bus.REQ1_READY = grant_id;
                    state_nxt      = EXEC;
                end
            end
            EXEC: begin
                case (fun_p0[3:2])
                    2'b00: bus.ARITH_EN = 1'b1;
                    2'b01: bus.LOGIC_EN = 1'b1;
                    2'b10: bus.CMP_EN   = 1'b1;
                    2'b11: bus.SHIFT_EN = 1'b1;
                endcase
                state_nxt = CAPT;
            end
            CAPT: begin
                state_nxt = RESP;
            end
            RESP: begin
                if (bus.RSP_READY) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- stage p0: winner's operands latched on the accept edge ----
    // Private copy so the requester may change its inputs once accepted.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            a_p0   <= '0;
            b_p0   <= '0;
            fun_p0 <= '0;
            id_p0  <= 1'b0;
        end else if (accept) begin
            a_p0   <= grant_id ? bus.REQ1_A   : bus.REQ0_A;
            b_p0   <= grant_id ? bus.REQ1_B   : bus.REQ0_B;
            fun_p0 <= grant_id ? bus.REQ1_FUN : bus.REQ0_FUN;
            id_p0  <= grant_id;
        end
    end

    // ---- stage p1: registered unit result captured at the end of CAPT ----
    // Response fields only ever change here, so they stay stable through RESP.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_p1 <= '0;
            flag_p1 <= 1'b0;
            id_p1   <= 1'b0;
        end else if (state == CAPT) begin
            data_p1 <= bus.ALU_OUT;
            flag_p1 <= bus.ALU_FLAG;
            id_p1   <= id_p0;
        end
    end

    assign bus.ALU_A     = a_p0;
    assign bus.ALU_B     = b_p0;
    assign bus.ALU_FUN   = fun_p0;

    assign bus.RSP_VALID = (state == RESP);
    assign bus.RSP_ID    = id_p1;
    assign bus.RSP_DATA  = data_p1;
    assign bus.RSP_FLAG  = flag_p1;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: a registered ALU model on the unit enables,
// a transaction-level reference of the arbiter checked every falling edge,
// and directed scenarios with literal expected values.
module tb_alu_req_arbiter;

    localparam int W = 16;

    logic CLK = 1'b0;
    logic RST;

    alu_req_arbiter_if #(.In_out(W)) bus ();

    alu_req_arbiter #(.In_out(W)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU: {flag, result}.
    function automatic logic [16:0] alu_ref(input logic [15:0] a, input logic [15:0] b,
                                            input logic [3:0] fun);
        logic [16:0]        s;
        logic [15:0]        r;
        logic               f;
        logic [3:0]         sh;
        logic signed [15:0] as_s;
        r    = 16'd0;
        f    = 1'b0;
        sh   = b[3:0];
        as_s = a;
        case (fun[3:2])
            2'b00: begin
                if (fun[0] == 1'b0) s = {1'b0, a} + {1'b0, b};
                else                s = {1'b0, a} - {1'b0, b};
                r = s[15:0];
                f = s[16];
            end
            2'b01: begin
                case (fun[1:0])
                    2'd0:    r = a & b;
                    2'd1:    r = a | b;
                    2'd2:    r = a ^ b;
                    default: r = ~a;
                endcase
                f = (r == 16'd0);
            end
            2'b10: begin
                case (fun[1:0])
                    2'd0:    f = (a < b);
                    2'd1:    f = (a == b);
                    2'd2:    f = (a > b);
                    default: f = (a != b);
                endcase
                r = {15'd0, f};
            end
            default: begin
                case (fun[1:0])
                    2'd0:    r = a << sh;
                    2'd1:    r = a >> sh;
                    2'd2:    r = as_s >>> sh;
                    default: r = (a << sh) | (a >> (5'd16 - {1'b0, sh}));
                endcase
            end
        endcase
        return {f, r};
    endfunction

    // Each unit computes only its own class; the ALU output is the OR of all units.
    function automatic logic [16:0] units(input logic ae, input logic le, input logic ce,
                                          input logic se, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] fun);
        logic [16:0] acc;
        acc = 17'd0;
        if (ae) acc = acc | alu_ref(a, b, {2'b00, fun[1:0]});
        if (le) acc = acc | alu_ref(a, b, {2'b01, fun[1:0]});
        if (ce) acc = acc | alu_ref(a, b, {2'b10, fun[1:0]});
        if (se) acc = acc | alu_ref(a, b, {2'b11, fun[1:0]});
        return acc;
    endfunction

    logic [15:0] alu_q = 16'd0;
    logic        alu_f = 1'b0;

    // Registered ALU units driven by the arbiter's enables.
    always @(posedge CLK) begin
        {alu_f, alu_q} <= units(bus.ARITH_EN, bus.LOGIC_EN, bus.CMP_EN, bus.SHIFT_EN,
                                bus.ALU_A, bus.ALU_B, bus.ALU_FUN);
    end

    assign bus.ALU_OUT  = alu_q;
    assign bus.ALU_FLAG = alu_f;

    // ---------------- transaction-level reference ----------------
    // m_age counts edges since the accept edge: 1 = execute cycle,
    // 2 = capture cycle, 3 = response offered.
    bit          m_busy;
    int          m_age;
    bit          m_id;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [3:0]  m_fun;
    logic [15:0] m_data;
    bit          m_flag;
    bit          m_rid;
    bit          m_ptr;
    int          m_pick;

    function automatic int pick(input logic v0, input logic v1, input bit ptr);
        if (v0 && v1) return int'(ptr);
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    assign m_pick = pick(bus.REQ0_VALID, bus.REQ1_VALID, m_ptr);

    function automatic logic [3:0] exp_en(input logic [3:0] fun);
        return 4'b1000 >> fun[3:2];
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_busy <= 1'b0;
            m_age  <= 0;
            m_data <= 16'd0;
            m_flag <= 1'b0;
            m_rid  <= 1'b0;
            m_ptr  <= 1'b0;
        end else if (!m_busy) begin
            if (m_pick >= 0) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_id   <= (m_pick == 1);
                m_a    <= (m_pick == 1) ? bus.REQ1_A   : bus.REQ0_A;
                m_b    <= (m_pick == 1) ? bus.REQ1_B   : bus.REQ0_B;
                m_fun  <= (m_pick == 1) ? bus.REQ1_FUN : bus.REQ0_FUN;
`ifdef ALU_ARB_RR_EN
                m_ptr  <= (m_pick == 0);
`endif
            end
        end else if (m_age == 2) begin
            {m_flag, m_data} <= alu_ref(m_a, m_b, m_fun);
            m_rid <= m_id;
            m_age <= 3;
        end else if (m_age == 3) begin
            if (bus.RSP_READY) begin
                m_busy <= 1'b0;
                m_age  <= 0;
            end
        end else begin
            m_age <= m_age + 1;
        end
    end

    // Per-cycle comparison against the reference.
    always @(negedge CLK) begin
        if (RST === 1'b1) begin
            chk("m_ready0", 32'(bus.REQ0_READY), 32'(!m_busy && m_pick == 0));
            chk("m_ready1", 32'(bus.REQ1_READY), 32'(!m_busy && m_pick == 1));
            chk("m_enables", 32'({bus.ARITH_EN, bus.LOGIC_EN, bus.CMP_EN, bus.SHIFT_EN}),
                32'((m_busy && m_age == 1) ? exp_en(m_fun) : 4'd0));
            chk("m_rsp_valid", 32'(bus.RSP_VALID), 32'(m_busy && m_age == 3));
            chk("m_rsp_data", 32'(bus.RSP_DATA), 32'(m_data));
            chk("m_rsp_flag", 32'(bus.RSP_FLAG), 32'(m_flag));
            if (m_busy && m_age == 3) begin
                chk("m_rsp_id", 32'(bus.RSP_ID), 32'(m_rid));
            end
            if (m_busy && (m_age == 1 || m_age == 2)) begin
                chk("m_alu_a", 32'(bus.ALU_A), 32'(m_a));
                chk("m_alu_b", 32'(bus.ALU_B), 32'(m_b));
                chk("m_alu_fun", 32'(bus.ALU_FUN), 32'(m_fun));
            end
        end
    end

    // Accept log for the arbitration-order scenario.
    bit log_en = 1'b0;
    int grants[$];

    always @(posedge CLK) begin
        if (log_en) begin
            if (bus.REQ0_READY && bus.REQ0_VALID) grants.push_back(0);
            if (bus.REQ1_READY && bus.REQ1_VALID) grants.push_back(1);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input bit id, input logic [15:0] a, input logic [15:0] b,
                           input logic [3:0] fun, input logic v);
        if (id) begin
            bus.REQ1_A = a; bus.REQ1_B = b; bus.REQ1_FUN = fun; bus.REQ1_VALID = v;
        end else begin
            bus.REQ0_A = a; bus.REQ0_B = b; bus.REQ0_FUN = fun; bus.REQ0_VALID = v;
        end
    endtask

    // Waits (bounded) for READY on requester id; returns just after the accept edge
    // with that requester's VALID dropped.
    task automatic wait_accept(input bit id, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if ((id ? bus.REQ1_READY : bus.REQ0_READY) === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept_seen", 32'(ok), 32'd1);
        @(posedge CLK);
        #1;
        if (id) bus.REQ1_VALID = 1'b0;
        else    bus.REQ0_VALID = 1'b0;
    endtask

    task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b,
                          input logic [3:0] fun, input logic [15:0] exp_d, input bit exp_f,
                          input logic [3:0] en, input bit mutate, input string tag);
        bit ok;
        @(posedge CLK);
        #1;
        set_req(id, a, b, fun, 1'b1);
        wait_accept(id, ok);
        if (!ok) return;
        if (mutate) set_req(id, 16'hFFFF, 16'h0000, 4'h0, 1'b0);
        @(negedge CLK);
        chk({tag, "_en_exec"}, 32'({bus.ARITH_EN, bus.LOGIC_EN, bus.CMP_EN, bus.SHIFT_EN}), 32'(en));
        chk({tag, "_valid_exec"}, 32'(bus.RSP_VALID), 32'd0);
        @(negedge CLK);
        chk({tag, "_en_capt"}, 32'({bus.ARITH_EN, bus.LOGIC_EN, bus.CMP_EN, bus.SHIFT_EN}), 32'd0);
        chk({tag, "_valid_capt"}, 32'(bus.RSP_VALID), 32'd0);
        @(negedge CLK);
        chk({tag, "_valid"}, 32'(bus.RSP_VALID), 32'd1);
        chk({tag, "_data"}, 32'(bus.RSP_DATA), 32'(exp_d));
        chk({tag, "_flag"}, 32'(bus.RSP_FLAG), 32'(exp_f));
        chk({tag, "_id"}, 32'(bus.RSP_ID), 32'(id));
        @(posedge CLK);
        #1;
    endtask

    typedef struct {
        bit          id;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic [15:0] d;
        bit          f;
        logic [3:0]  en;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time bound");
        $fatal(1, "bench timed out");
    end

    initial begin
        bit ok;
        bus.REQ0_VALID = 1'b0; bus.REQ1_VALID = 1'b0;
        bus.REQ0_A = 16'd0; bus.REQ0_B = 16'd0; bus.REQ0_FUN = 4'd0;
        bus.REQ1_A = 16'd0; bus.REQ1_B = 16'd0; bus.REQ1_FUN = 4'd0;
        bus.RSP_READY = 1'b1;
        RST = 1'b1;
        #1 RST = 1'b0;
        #2;
        chk("rst_rsp_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("rst_rsp_data", 32'(bus.RSP_DATA), 32'd0);
        chk("rst_rsp_flag", 32'(bus.RSP_FLAG), 32'd0);
        chk("rst_rsp_id", 32'(bus.RSP_ID), 32'd0);
        chk("rst_alu_a", 32'(bus.ALU_A), 32'd0);
        chk("rst_alu_b", 32'(bus.ALU_B), 32'd0);
        chk("rst_alu_fun", 32'(bus.ALU_FUN), 32'd0);
        chk("rst_enables", 32'({bus.ARITH_EN, bus.LOGIC_EN, bus.CMP_EN, bus.SHIFT_EN}), 32'd0);
        repeat (2) @(posedge CLK);
        #2 RST = 1'b1;

        // Add from requester 0, equality compare from requester 1.
        run_op(1'b0, 16'h0005, 16'h0003, 4'h0, 16'h0008, 1'b0, 4'b1000, 1'b0, "t_add");
        run_op(1'b1, 16'h1234, 16'h1234, 4'h9, 16'h0001, 1'b1, 4'b0010, 1'b0, "t_cmpeq");

        // Assorted unit classes and carry/borrow/sign boundaries.
        tbl[0] = '{1'b0, 16'h00F0, 16'h0F0F, 4'h6, 16'h0FFF, 1'b0, 4'b0100};
        tbl[1] = '{1'b1, 16'h0001, 16'h0002, 4'h1, 16'hFFFF, 1'b1, 4'b1000};
        tbl[2] = '{1'b0, 16'h8000, 16'h0003, 4'hE, 16'hF000, 1'b0, 4'b0001};
        tbl[3] = '{1'b1, 16'hFFFF, 16'h0001, 4'h0, 16'h0000, 1'b1, 4'b1000};
        tbl[4] = '{1'b0, 16'h0003, 16'h0005, 4'h8, 16'h0001, 1'b1, 4'b0010};
        tbl[5] = '{1'b1, 16'h00FF, 16'h0F00, 4'h7, 16'hFF00, 1'b0, 4'b0100};
        for (int i = 0; i < 6; i++) begin
            run_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].fun, tbl[i].d, tbl[i].f,
                   tbl[i].en, 1'b0, "t_tbl");
        end

        // Both requesters valid continuously: record four grants.
        @(posedge CLK);
        #1;
        grants.delete();
        log_en = 1'b1;
        set_req(1'b0, 16'h0001, 16'h0001, 4'h0, 1'b1);
        set_req(1'b1, 16'h0002, 16'h0002, 4'h0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (grants.size() >= 4) break;
        end
        @(posedge CLK);
        #1;
        bus.REQ0_VALID = 1'b0;
        bus.REQ1_VALID = 1'b0;
        log_en = 1'b0;
        chk("t_arb_count", 32'(grants.size()), 32'd4);
        for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
            chk("t_arb_grant", (k < grants.size()) ? 32'(grants[k]) : 32'hDEAD, 32'(k % 2));
`else
            chk("t_arb_grant", (k < grants.size()) ? 32'(grants[k]) : 32'hDEAD, 32'd0);
`endif
        end
        repeat (4) @(posedge CLK);
        #1;

        // Response back-pressure: RSP_READY low while the response is held.
        bus.RSP_READY = 1'b0;
        set_req(1'b1, 16'h00FF, 16'h0001, 4'h0, 1'b0);
        set_req(1'b0, 16'h00F0, 16'h0F0F, 4'h5, 1'b1);
        wait_accept(1'b0, ok);
        bus.REQ1_VALID = 1'b1;
        repeat (2) @(negedge CLK);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("t_bp_valid", 32'(bus.RSP_VALID), 32'd1);
            chk("t_bp_data", 32'(bus.RSP_DATA), 32'h0FFF);
            chk("t_bp_ready0", 32'(bus.REQ0_READY), 32'd0);
            chk("t_bp_ready1", 32'(bus.REQ1_READY), 32'd0);
        end
        @(posedge CLK);
        #1 bus.RSP_READY = 1'b1;
        @(negedge CLK);
        chk("t_bp_still_valid", 32'(bus.RSP_VALID), 32'd1);
        @(negedge CLK);
        chk("t_bp_regrant", 32'(bus.REQ1_READY), 32'd1);
        @(posedge CLK);
        #1 bus.REQ1_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t_bp_next_data", 32'(bus.RSP_DATA), 32'h0100);
        @(posedge CLK);
        #1;

        // Reset during the capture cycle abandons the operation.
        set_req(1'b0, 16'h0007, 16'h0002, 4'h1, 1'b1);
        wait_accept(1'b0, ok);
        @(posedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("t_rst_valid", 32'(bus.RSP_VALID), 32'd0);
        chk("t_rst_data", 32'(bus.RSP_DATA), 32'd0);
        chk("t_rst_flag", 32'(bus.RSP_FLAG), 32'd0);
        chk("t_rst_id", 32'(bus.RSP_ID), 32'd0);
        chk("t_rst_alu_a", 32'(bus.ALU_A), 32'd0);
        chk("t_rst_alu_b", 32'(bus.ALU_B), 32'd0);
        chk("t_rst_alu_fun", 32'(bus.ALU_FUN), 32'd0);
        chk("t_rst_en", 32'({bus.ARITH_EN, bus.LOGIC_EN, bus.CMP_EN, bus.SHIFT_EN}), 32'd0);
        repeat (2) @(posedge CLK);
        #1 chk("t_rst_hold_valid", 32'(bus.RSP_VALID), 32'd0);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1;
        set_req(1'b0, 16'h0010, 16'h0020, 4'h0, 1'b1);
        set_req(1'b1, 16'h0030, 16'h0001, 4'h1, 1'b1);
        @(negedge CLK);
        chk("t_rst_first_grant0", 32'(bus.REQ0_READY), 32'd1);
        chk("t_rst_first_grant1", 32'(bus.REQ1_READY), 32'd0);
        @(posedge CLK);
        #1 bus.REQ0_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t_rst_op_valid", 32'(bus.RSP_VALID), 32'd1);
        chk("t_rst_op_data", 32'(bus.RSP_DATA), 32'h0030);
        chk("t_rst_op_id", 32'(bus.RSP_ID), 32'd0);
        @(negedge CLK);
        chk("t_rst_next_grant", 32'(bus.REQ1_READY), 32'd1);
        @(posedge CLK);
        #1 bus.REQ1_VALID = 1'b0;
        repeat (3) @(negedge CLK);
        chk("t_rst_op1_data", 32'(bus.RSP_DATA), 32'h002F);
        chk("t_rst_op1_id", 32'(bus.RSP_ID), 32'd1);
        @(posedge CLK);
        #1;

        // Requester rewrites its operands right after acceptance.
        run_op(1'b1, 16'h0003, 16'h0002, 4'hC, 16'h000C, 1'b0, 4'b0001, 1'b1, "t_mutate");

        repeat (3) @(posedge CLK);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 SHALL have parameter: In_out, 16, operand/result width.
REQ-002 SHALL have port: CLK  input  1  rising-edge clock.
REQ-003 SHALL have port: RST  input  1  asynchronous reset, active-low.
REQ-004 SHALL have ports: REQ0_VALID, REQ1_VALID  input  1  requester n has an operation pending.
REQ-005 SHALL have ports: REQ0_READY, REQ1_READY  output  1  requester n operation accepted this cycle.
REQ-006 SHALL have ports: REQ0_A, REQ0_B, REQ1_A, REQ1_B  input  In_out  operands.
REQ-007 SHALL have ports: REQ0_FUN, REQ1_FUN  input  4  ALU function code.
REQ-008 SHALL have ports: ALU_A, ALU_B  output  In_out; ALU_FUN  output  4  shared-ALU operand/function drive.
REQ-009 SHALL have ports: ARITH_EN, LOGIC_EN, CMP_EN, SHIFT_EN  output  1  unit enables.
REQ-010 SHALL have ports: ALU_OUT  input  In_out; ALU_FLAG  input  1  OR of all registered unit outputs/flags.
REQ-011 SHALL have ports: RSP_VALID  output  1; RSP_READY  input  1; RSP_ID  output  1; RSP_DATA  output  In_out; RSP_FLAG  output  1  response channel.

Function
REQ-012 SHALL implement FSM states IDLE, EXEC, CAPT, RESP.
REQ-013 IDLE: SHALL assert exactly one READY, combinationally, to the granted valid requester; no READY outside IDLE.
REQ-014 On accept edge SHALL latch winner's A, B, FUN, ID into internal registers and go IDLE->EXEC; no valid requester stays IDLE.
REQ-015 EXEC: SHALL drive latched A/B/FUN onto ALU_A/ALU_B/ALU_FUN and assert exactly one enable by FUN[3:2] (00 ARITH, 01 LOGIC, 10 CMP, 11 SHIFT) for exactly one cycle; go CAPT.
REQ-016 CAPT: all enables low, ALU_A/B/FUN held; at end of cycle SHALL register ALU_OUT->RSP_DATA, ALU_FLAG->RSP_FLAG; go RESP.
REQ-017 RESP: SHALL hold RSP_VALID=1 and RSP_ID/DATA/FLAG stable until RSP_VALID&RSP_READY sampled, then go IDLE.
REQ-018 Latency: RSP_VALID SHALL rise on the 2nd rising edge after the accept edge; min issue interval 4 cycles with RSP_READY tied high.
REQ-019 Requester changing A/B/FUN after acceptance SHALL NOT affect the in-flight operation.
REQ-020 Requester dropping VALID while not granted SHALL lose no state; no request buffering beyond one in flight.
REQ-021 RSP_DATA/RSP_FLAG SHALL NOT be modified outside CAPT.

Reset
REQ-022 RST low SHALL asynchronously force state IDLE, all enables 0, RSP_VALID 0, RSP_ID 0, RSP_DATA 0, RSP_FLAG 0, ALU_A/ALU_B 0, ALU_FUN 0, round-robin pointer to requester 0.
REQ-023 Reset mid-operation SHALL abandon the in-flight op without a response; first grant after release SHALL follow REQ-022 pointer.

Configuration
REQ-024 Macro ALU_ARB_RR_EN: defined -> round-robin; both valid in IDLE grant the requester not granted last; pointer updates only on accept.
REQ-025 ALU_ARB_RR_EN undefined -> fixed priority: requester 0 always wins ties; no pointer register.

Verification
REQ-026 REQ0 only, A=0x0005 B=0x0003 FUN=0x0 (add), RSP_READY=1 -> ARITH_EN one cycle; RSP_VALID 2 edges after accept, RSP_ID=0, RSP_DATA=0x0008.
REQ-027 REQ1 only, A=B=0x1234 FUN=0x9 (CMP eq) -> CMP_EN one cycle, RSP_ID=1, RSP_DATA=0x0001, RSP_FLAG=1.
REQ-028 Both valid continuously, RR build -> grants alternate 0,1,0,1; fixed build -> all four grants to 0.
REQ-029 RSP_READY held low 5 cycles in RESP -> RSP_VALID/DATA stable, both READY low; release -> IDLE next edge, new grant.
REQ-030 RST low during CAPT -> outputs at reset values immediately, no RSP_VALID; after release REQ0 op completes normally.
REQ-031 Requester changes A/B/FUN the cycle after accept -> RSP_DATA reflects originally latched values.
